// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 4-digit scan with guard gaps, masking, blinking and frame-aligned value updates
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [2:0] val0,
    input  logic [2:0] val1,
    input  logic [2:0] val2,
    input  logic [2:0] val3,
    input  logic [3:0] digit_mask,
    input  logic [3:0] blink_mask,
    output logic [2:0] sel,
    output logic       blank,
    output logic [3:0] dig,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, SCAN, GUARD} state_t;
    state_t st, nst;
    logic [15:0] div_cnt, ndiv;
    logic [1:0] idx, nidx;
    logic [7:0] fcnt, nfcnt;
    logic ph, nph, copy, show, ndone;
    logic [3:0][2:0] in_v, pv, av, nav;
    logic [3:0] pdm, pbm, adm, abm, nadm, nabm;
    assign in_v = {val3, val2, val1, val0};
    // Everything is computed for the upcoming cycle so outputs register in step with the state.
    always_comb begin
        nst = st;
        ndiv = div_cnt;
        nidx = idx;
        nfcnt = fcnt;
        nph = ph;
        copy = 1'b0;
        ndone = 1'b0;
        if (!enable) begin
            nst = IDLE;
            ndiv = '0;
            nidx = '0;
            nfcnt = '0;
            nph = 1'b0;
        end else if (st == IDLE) begin
            nst = SCAN;
            ndiv = '0;
            nidx = '0;
            nfcnt = '0;
            nph = 1'b0;
            copy = 1'b1;
        end else if (st == SCAN) begin
            nst = (div_cnt == 16'(REFRESH_DIV - 1)) ? GUARD : SCAN;
            ndiv = (div_cnt == 16'(REFRESH_DIV - 1)) ? '0 : div_cnt + 16'd1;
            ndone = (div_cnt == 16'(REFRESH_DIV - 1)) && (idx == 2'd3);
        end else begin
            nst = SCAN;
            nidx = idx + 2'd1;
            copy = (idx == 2'd3);
            nfcnt = (idx != 2'd3) ? fcnt : (fcnt == 8'(BLINK_FRAMES - 1)) ? '0 : fcnt + 8'd1;
            nph = ph ^ ((idx == 2'd3) && (fcnt == 8'(BLINK_FRAMES - 1)));
        end
        nav = copy ? (load ? in_v : pv) : av;
        nadm = copy ? (load ? digit_mask : pdm) : adm;
        nabm = copy ? (load ? blink_mask : pbm) : abm;
        show = (nst == SCAN) && nadm[nidx] && !(nabm[nidx] && nph);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= IDLE;
            div_cnt <= '0;
            idx <= '0;
            fcnt <= '0;
            ph <= 1'b0;
            pv <= '0;
            av <= '0;
            pdm <= '0;
            pbm <= '0;
            adm <= '0;
            abm <= '0;
            sel <= '0;
            blank <= 1'b1;
            dig <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            st <= nst;
            div_cnt <= ndiv;
            idx <= nidx;
            fcnt <= nfcnt;
            ph <= nph;
            pv <= load ? in_v : pv;
            pdm <= load ? digit_mask : pdm;
            pbm <= load ? blink_mask : pbm;
            av <= nav;
            adm <= nadm;
            abm <= nabm;
            sel <= (nst == SCAN) ? nav[nidx] : 3'd0;
            blank <= !show;
            dig <= show ? ~(4'b0001 << nidx) : 4'b1111;
            frame_done <= ndone;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench against a time-slot reference model of the scan controller
module tb_display_scan_ctrl;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int SLOT = RD + 1;
    localparam int FR = 4 * SLOT;
    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b0, load = 1'b0;
    logic [2:0] val0 = '0, val1 = '0, val2 = '0, val3 = '0;
    logic [3:0] digit_mask = '0, blink_mask = '0;
    logic [2:0] sel;
    logic blank, frame_done;
    logic [3:0] dig;
    int checks = 0, errors = 0;
    logic [8:0] expq[$];
    logic [2:0] m_pv[4], m_av[4];
    logic [3:0] m_pdm = '0, m_pbm = '0, m_adm = '0, m_abm = '0;
    bit running = 0;
    int t = 0;

    display_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .digit_mask(digit_mask), .blink_mask(blink_mask),
        .sel(sel), .blank(blank), .dig(dig), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference: position in the scan is derived from elapsed cycles since scan start.
    task automatic model();
        logic [2:0] in_v[4];
        bit newf, guard, show;
        int d, f;
        logic [8:0] e;
        in_v = '{val0, val1, val2, val3};
        newf = 0;
        if (reset) begin
            running = 0;
            foreach (m_pv[i]) begin m_pv[i] = '0; m_av[i] = '0; end
            m_pdm = '0; m_pbm = '0; m_adm = '0; m_abm = '0;
        end else begin
            if (!enable) running = 0;
            else if (!running) begin running = 1; t = 0; newf = 1; end
            else begin t++; newf = (t % FR) == 0; end
            if (newf) begin
                foreach (m_av[i]) m_av[i] = load ? in_v[i] : m_pv[i];
                m_adm = load ? digit_mask : m_pdm;
                m_abm = load ? blink_mask : m_pbm;
            end
            if (load) begin
                foreach (m_pv[i]) m_pv[i] = in_v[i];
                m_pdm = digit_mask;
                m_pbm = blink_mask;
            end
        end
        if (!running) e = {3'd0, 1'b1, 4'b1111, 1'b0};
        else begin
            guard = (t % SLOT) == RD;
            d = (t / SLOT) % 4;
            f = t / FR;
            show = !guard && m_adm[d] && !(m_abm[d] && ((f / BF) % 2 == 1));
            e = {guard ? 3'd0 : m_av[d], !show, show ? ~(4'b0001 << d) : 4'b1111, guard && d == 3};
        end
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            load = 1'b0;
        end
    endtask

    task automatic set_in(input logic [2:0] a, b, c, d, input logic [3:0] dm, bm);
        val0 = a; val1 = b; val2 = c; val3 = d;
        digit_mask = dm; blink_mask = bm; load = 1'b1;
    endtask

    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({sel, blank, dig, frame_done} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got sel=%0d blank=%0b dig=%b fd=%0b, want sel=%0d blank=%0b dig=%b fd=%0b",
                             $time, sel, blank, dig, frame_done, e[8:6], e[5], e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        #1;
        cyc(3);
        reset = 1'b0;
        set_in(3'd1, 3'd2, 3'd3, 3'd4, 4'b1111, 4'b0000);
        cyc(2);
        enable = 1'b1;
        cyc(27);
        set_in(3'd5, 3'd6, 3'd7, 3'd0, 4'b1010, 4'b0000);
        cyc(50);
        set_in(3'd2, 3'd3, 3'd4, 3'd5, 4'b1111, 4'b0001);
        cyc(200);
        cyc(11);
        enable = 1'b0;
        cyc(3);
        set_in(3'd7, 3'd6, 3'd5, 3'd4, 4'b0110, 4'b0100);
        cyc(2);
        enable = 1'b1;
        cyc(37);
        reset = 1'b1;
        set_in(3'd3, 3'd3, 3'd3, 3'd3, 4'b1111, 4'b1111);
        cyc(1);
        reset = 1'b0;
        cyc(25);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0)
                set_in(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom));
            else load = 1'b0;
            tick();
        end
        load = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
